// File: rtl/tc0_pkg.sv
// Shared constants and types for the Timer/Counter0 control block.
// Optional external clock source is enabled by defining TC0_EXT_CLK_EN.
package tc0_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned PSC_W   = 10;
  localparam int unsigned FLAG_W  = 3;
  localparam int unsigned TCCRB_W = 6;
  localparam int unsigned VEC_W   = 2;

  // I/O alias and data-space alias of every register
  localparam logic [ADDR_W-1:0] ADDR_TCCR0A_IO = 8'h24;
  localparam logic [ADDR_W-1:0] ADDR_TCCR0A_DS = 8'h44;
  localparam logic [ADDR_W-1:0] ADDR_TCCR0B_IO = 8'h25;
  localparam logic [ADDR_W-1:0] ADDR_TCCR0B_DS = 8'h45;
  localparam logic [ADDR_W-1:0] ADDR_TCNT0_IO  = 8'h26;
  localparam logic [ADDR_W-1:0] ADDR_TCNT0_DS  = 8'h46;
  localparam logic [ADDR_W-1:0] ADDR_OCR0A_IO  = 8'h27;
  localparam logic [ADDR_W-1:0] ADDR_OCR0A_DS  = 8'h47;
  localparam logic [ADDR_W-1:0] ADDR_OCR0B_IO  = 8'h28;
  localparam logic [ADDR_W-1:0] ADDR_OCR0B_DS  = 8'h48;
  localparam logic [ADDR_W-1:0] ADDR_TIFR0_IO  = 8'h15;
  localparam logic [ADDR_W-1:0] ADDR_TIFR0_DS  = 8'h35;
  localparam logic [ADDR_W-1:0] ADDR_TIMSK0    = 8'h6E;

  localparam int unsigned TOV0_BIT  = 0;
  localparam int unsigned OCF0A_BIT = 1;
  localparam int unsigned OCF0B_BIT = 2;

  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_DIV1     = 3'd1,
    CS_DIV8     = 3'd2,
    CS_DIV64    = 3'd3,
    CS_DIV256   = 3'd4,
    CS_DIV1024  = 3'd5,
    CS_EXT_FALL = 3'd6,
    CS_EXT_RISE = 3'd7
  } cs0_e;

  typedef enum logic [VEC_W-1:0] {
    IRQ_COMPA = 2'd0,
    IRQ_COMPB = 2'd1,
    IRQ_OVF   = 2'd2
  } irq_vec_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } irq_state_e;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TCCRA,
    REG_TCCRB,
    REG_TCNT,
    REG_OCRA,
    REG_OCRB,
    REG_TIMSK,
    REG_TIFR
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
    case (addr)
      ADDR_TCCR0A_IO, ADDR_TCCR0A_DS: return REG_TCCRA;
      ADDR_TCCR0B_IO, ADDR_TCCR0B_DS: return REG_TCCRB;
      ADDR_TCNT0_IO,  ADDR_TCNT0_DS:  return REG_TCNT;
      ADDR_OCR0A_IO,  ADDR_OCR0A_DS:  return REG_OCRA;
      ADDR_OCR0B_IO,  ADDR_OCR0B_DS:  return REG_OCRB;
      ADDR_TIFR0_IO,  ADDR_TIFR0_DS:  return REG_TIFR;
      ADDR_TIMSK0:                    return REG_TIMSK;
      default:                        return REG_NONE;
    endcase
  endfunction

  // One-hot TIFR/TIMSK position of an interrupt source
  function automatic logic [FLAG_W-1:0] vec_flag(input irq_vec_e v);
    case (v)
      IRQ_COMPA: return FLAG_W'(1) << OCF0A_BIT;
      IRQ_COMPB: return FLAG_W'(1) << OCF0B_BIT;
      IRQ_OVF:   return FLAG_W'(1) << TOV0_BIT;
      default:   return '0;
    endcase
  endfunction

  // Fixed priority COMPA > COMPB > OVF; caller guarantees p is non-zero
  function automatic irq_vec_e pick_src(input logic [FLAG_W-1:0] p);
    if (p[OCF0A_BIT])      return IRQ_COMPA;
    else if (p[OCF0B_BIT]) return IRQ_COMPB;
    else                   return IRQ_OVF;
  endfunction

endpackage

// File: rtl/tc0_if.sv
// Bus, counter-core and interrupt signals of the Timer/Counter0 controller.
interface tc0_if;
  logic [7:0] io_addr;
  logic       io_wr_en;
  logic       io_rd_en;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic [7:0] tcnt_in;
  logic       tcnt_wr;
  logic [7:0] tcnt_wdata;
  logic [7:0] tccra;
  logic [7:0] tccrb;
  logic [7:0] ocra;
  logic [7:0] ocrb;
  logic       ovf_evt;
  logic       cmpa_evt;
  logic       cmpb_evt;
  logic       t0_pin;
  logic       tick;
  logic       irq;
  logic [1:0] irq_vec;
  logic       irq_ack;

  modport slave (
    input  io_addr, io_wr_en, io_rd_en, io_wdata, tcnt_in,
    input  ovf_evt, cmpa_evt, cmpb_evt, t0_pin, irq_ack,
    output io_rdata, tcnt_wr, tcnt_wdata, tccra, tccrb, ocra, ocrb,
    output tick, irq, irq_vec
  );

  modport master (
    output io_addr, io_wr_en, io_rd_en, io_wdata, tcnt_in,
    output ovf_evt, cmpa_evt, cmpb_evt, t0_pin, irq_ack,
    input  io_rdata, tcnt_wr, tcnt_wdata, tccra, tccrb, ocra, ocrb,
    input  tick, irq, irq_vec
  );
endinterface

// File: rtl/tc0_prescaler.sv
// Free-running prescaler and count-enable tick generation for Timer/Counter0.
// External pin clocking (CS0 6/7) exists only when TC0_EXT_CLK_EN is defined.
module tc0_prescaler
  import tc0_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_cs,
  input  logic       i_t0_pin,
  output logic       o_tick
);

  logic [PSC_W-1:0] r_psc;
  logic             r_tick;
  logic             w_match;
  logic             w_ext_rise;
  logic             w_ext_fall;

  always_ff @(posedge clk) begin
    if (!rst) r_psc <= '0;
    else      r_psc <= r_psc + PSC_W'(1);
  end

`ifdef TC0_EXT_CLK_EN
  logic r_t0_s1;
  logic r_t0_s2;
  logic r_t0_d;

  // Two-stage synchronizer plus one edge-history flop
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_t0_s1 <= 1'b0;
      r_t0_s2 <= 1'b0;
      r_t0_d  <= 1'b0;
    end else begin
      r_t0_s1 <= i_t0_pin;
      r_t0_s2 <= r_t0_s1;
      r_t0_d  <= r_t0_s2;
    end
  end

  assign w_ext_rise = r_t0_s2 & ~r_t0_d;
  assign w_ext_fall = ~r_t0_s2 & r_t0_d;
`else
  logic w_unused_t0;
  assign w_unused_t0 = i_t0_pin;
  assign w_ext_rise  = 1'b0;
  assign w_ext_fall  = 1'b0;
`endif

  always_comb begin
    w_match = 1'b0;
    case (cs0_e'(i_cs))
      CS_STOP:     w_match = 1'b0;
      CS_DIV1:     w_match = 1'b1;
      CS_DIV8:     w_match = &r_psc[2:0];
      CS_DIV64:    w_match = &r_psc[5:0];
      CS_DIV256:   w_match = &r_psc[7:0];
      CS_DIV1024:  w_match = &r_psc[9:0];
      CS_EXT_FALL: w_match = w_ext_fall;
      CS_EXT_RISE: w_match = w_ext_rise;
      default:     w_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_tick <= 1'b0;
    else      r_tick <= w_match;
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/tc0_ctrl.sv
// Timer/Counter0 register file, TCNT0 access path and interrupt arbitration.
// Define TC0_EXT_CLK_EN to enable external t0_pin clocking in the prescaler.
module tc0_ctrl
  import tc0_pkg::*;
(
  input logic  clk,
  input logic  rst,
  tc0_if.slave bus
);

  logic [DATA_W-1:0]  r_tccra;
  logic [TCCRB_W-1:0] r_tccrb;
  logic [DATA_W-1:0]  r_ocra;
  logic [DATA_W-1:0]  r_ocrb;
  logic [FLAG_W-1:0]  r_timsk;
  logic [FLAG_W-1:0]  r_tifr;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_tcnt_wr;
  logic [DATA_W-1:0]  r_tcnt_wdata;

  irq_state_e r_state;
  irq_state_e w_state_n;
  irq_vec_e   r_vec;
  irq_vec_e   w_vec_n;
  logic       r_irq;
  logic       w_irq_n;

  reg_sel_e          w_sel;
  logic [DATA_W-1:0] w_rd_data;
  logic [FLAG_W-1:0] w_pend;
  logic [FLAG_W-1:0] w_hw_set;
  logic [FLAG_W-1:0] w_sw_clr;
  logic [FLAG_W-1:0] w_ack_clr;
  logic [FLAG_W-1:0] w_tifr_n;
  logic              w_tick;

  assign w_sel    = decode_addr(bus.io_addr);
  assign w_pend   = r_tifr & r_timsk;
  assign w_hw_set = {bus.cmpb_evt, bus.cmpa_evt, bus.ovf_evt};
  assign w_sw_clr = (bus.io_wr_en && (w_sel == REG_TIFR)) ? bus.io_wdata[FLAG_W-1:0] : '0;
  // A hardware event beats any same-cycle clear
  assign w_tifr_n = (r_tifr & ~(w_sw_clr | w_ack_clr)) | w_hw_set;

  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      REG_TCCRA: w_rd_data = r_tccra;
      REG_TCCRB: w_rd_data = DATA_W'(r_tccrb);
      REG_TCNT:  w_rd_data = bus.tcnt_in;
      REG_OCRA:  w_rd_data = r_ocra;
      REG_OCRB:  w_rd_data = r_ocrb;
      REG_TIMSK: w_rd_data = DATA_W'(r_timsk);
      REG_TIFR:  w_rd_data = DATA_W'(r_tifr);
      default:   w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tccra      <= '0;
      r_tccrb      <= '0;
      r_ocra       <= '0;
      r_ocrb       <= '0;
      r_timsk      <= '0;
      r_tifr       <= '0;
      r_rdata      <= '0;
      r_tcnt_wr    <= 1'b0;
      r_tcnt_wdata <= '0;
    end else begin
      r_tifr    <= w_tifr_n;
      r_tcnt_wr <= 1'b0;
      if (bus.io_rd_en) r_rdata <= w_rd_data;
      if (bus.io_wr_en) begin
        case (w_sel)
          REG_TCCRA: r_tccra <= bus.io_wdata;
          REG_TCCRB: r_tccrb <= bus.io_wdata[TCCRB_W-1:0];
          REG_TCNT: begin
            r_tcnt_wr    <= 1'b1;
            r_tcnt_wdata <= bus.io_wdata;
          end
          REG_OCRA:  r_ocra  <= bus.io_wdata;
          REG_OCRB:  r_ocrb  <= bus.io_wdata;
          REG_TIMSK: r_timsk <= bus.io_wdata[FLAG_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Interrupt arbitration: state, latched source and irq are all registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_vec   <= IRQ_COMPA;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_vec   <= w_vec_n;
      r_irq   <= w_irq_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_vec_n   = r_vec;
    w_irq_n   = 1'b0;
    w_ack_clr = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend != '0) begin
          w_vec_n   = pick_src(w_pend);
          w_state_n = ST_PEND;
          w_irq_n   = 1'b1;
        end
      end
      ST_PEND: begin
        w_irq_n = 1'b1;
        // Ack has precedence over a coincident withdraw
        if (bus.irq_ack) begin
          w_ack_clr = vec_flag(r_vec);
          w_state_n = ST_IDLE;
          w_irq_n   = 1'b0;
        end else if ((w_pend & vec_flag(r_vec)) == '0) begin
          w_state_n = ST_IDLE;
          w_irq_n   = 1'b0;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  tc0_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .i_cs     (r_tccrb[2:0]),
    .i_t0_pin (bus.t0_pin),
    .o_tick   (w_tick)
  );

  assign bus.io_rdata   = r_rdata;
  assign bus.tcnt_wr    = r_tcnt_wr;
  assign bus.tcnt_wdata = r_tcnt_wdata;
  assign bus.tccra      = r_tccra;
  assign bus.tccrb      = DATA_W'(r_tccrb);
  assign bus.ocra       = r_ocra;
  assign bus.ocrb       = r_ocrb;
  assign bus.tick       = w_tick;
  assign bus.irq        = r_irq;
  assign bus.irq_vec    = r_vec;

endmodule

// File: tb/tb_tc0_ctrl.sv
// Self-checking bench for tc0_ctrl: register table, directed corner cases
// and a randomized flag/interrupt run against a behavioural model.
module tb_tc0_ctrl;

  logic clk = 1'b0;
  logic rst;
  tc0_if bus ();

  tc0_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] raddr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.io_addr  = a;
    bus.io_wdata = d;
    bus.io_wr_en = 1'b1;
    step();
    bus.io_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.io_addr  = a;
    bus.io_rd_en = 1'b1;
    step();
    bus.io_rd_en = 1'b0;
    d = bus.io_rdata;
  endtask

  // Reference model state for the randomized phase
  logic [2:0] m_flags, m_mask;
  logic [7:0] m_rdata;
  logic       m_active;
  int         m_src;

  function automatic logic [2:0] src_bit(input int src);
    // source code -> flag position: COMPA=OCF0A(1), COMPB=OCF0B(2), OVF=TOV0(0)
    case (src)
      0:       return 3'b010;
      1:       return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  initial begin
    logic [7:0] d;
    logic [7:0] addrs[13];
    int last, cnt, gap_bad;

    bus.io_addr = '0; bus.io_wr_en = 0; bus.io_rd_en = 0; bus.io_wdata = '0;
    bus.tcnt_in = '0; bus.ovf_evt = 0; bus.cmpa_evt = 0; bus.cmpb_evt = 0;
    bus.t0_pin = 0; bus.irq_ack = 0;
    rst = 1'b0;
    step(); step();
    check("rst_irq", 32'(bus.irq), 0);
    check("rst_tick", 32'(bus.tick), 0);
    check("rst_tcnt_wr", 32'(bus.tcnt_wr), 0);
    check("rst_rdata", 32'(bus.io_rdata), 0);
    check("rst_vec", 32'(bus.irq_vec), 0);
    rst = 1'b1;

    // Every mapped alias reads zero after reset
    addrs = '{8'h24, 8'h44, 8'h25, 8'h45, 8'h26, 8'h46, 8'h27, 8'h47,
              8'h28, 8'h48, 8'h15, 8'h35, 8'h6E};
    foreach (addrs[i]) begin
      rd(addrs[i], d);
      check($sformatf("rst_read_%02h", addrs[i]), 32'(d), 0);
    end

    vecs[0] = '{8'h24, 8'hA5, 8'h44, 8'hA5};
    vecs[1] = '{8'h45, 8'hF8, 8'h25, 8'h38};
    vecs[2] = '{8'h27, 8'h5A, 8'h47, 8'h5A};
    vecs[3] = '{8'h48, 8'hC3, 8'h28, 8'hC3};
    vecs[4] = '{8'h6E, 8'hF8, 8'h6E, 8'h00};
    vecs[5] = '{8'h6F, 8'h55, 8'h6F, 8'h00};
    vecs[6] = '{8'h4E, 8'hFF, 8'h6E, 8'h00};
    vecs[7] = '{8'h35, 8'h07, 8'h15, 8'h00};
    vecs[8] = '{8'h44, 8'h3C, 8'h24, 8'h3C};
    foreach (vecs[i]) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, d);
      check($sformatf("table_%0d_rd_%02h", i, vecs[i].raddr), 32'(d), 32'(vecs[i].exp));
    end
    check("ocra_out", 32'(bus.ocra), 32'h5A);
    check("tccrb_out", 32'(bus.tccrb), 32'h38);

    // TCNT0 path
    bus.tcnt_in = 8'h9C;
    rd(8'h46, d);
    check("tcnt_read", 32'(d), 32'h9C);
    wr(8'h26, 8'h33);
    check("tcnt_wr_pulse", 32'(bus.tcnt_wr), 1);
    check("tcnt_wdata", 32'(bus.tcnt_wdata), 32'h33);
    step();
    check("tcnt_wr_drop", 32'(bus.tcnt_wr), 0);

    // Prescaler divide-by-8
    wr(8'h25, 8'h02);
    last = -1; cnt = 0; gap_bad = 0;
    for (int i = 0; i <= 80; i++) begin
      if (bus.tick) begin
        if (last >= 0 && (i - last) != 8) gap_bad++;
        last = i;
        cnt++;
      end
      step();
    end
    check("div8_count", 32'(cnt), 10);
    check("div8_gaps", 32'(gap_bad), 0);
    wr(8'h25, 8'h00);
    step();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.tick) cnt++;
      step();
    end
    check("stop_no_tick", 32'(cnt), 0);

    // Priority: COMPA served before OVF, one idle cycle between requests
    wr(8'h6E, 8'h07);
    bus.ovf_evt = 1; bus.cmpa_evt = 1;
    step();
    bus.ovf_evt = 0; bus.cmpa_evt = 0;
    check("prio_irq_n1", 32'(bus.irq), 0);
    step();
    check("prio_irq_n2", 32'(bus.irq), 1);
    check("prio_vec_compa", 32'(bus.irq_vec), 0);
    bus.irq_ack = 1;
    step();
    bus.irq_ack = 0;
    check("prio_ack_drop", 32'(bus.irq), 0);
    bus.io_addr = 8'h15; bus.io_rd_en = 1;
    step();
    bus.io_rd_en = 0;
    check("prio_tifr_after_ack", 32'(bus.io_rdata), 32'h01);
    check("prio_irq_again", 32'(bus.irq), 1);
    check("prio_vec_ovf", 32'(bus.irq_vec), 2);
    bus.irq_ack = 1;
    step();
    bus.irq_ack = 0;
    step();
    check("prio_idle", 32'(bus.irq), 0);

    // Flag set beats same-cycle software clear
    wr(8'h6E, 8'h00);
    bus.ovf_evt = 1;
    wr(8'h15, 8'h01);
    bus.ovf_evt = 0;
    rd(8'h15, d);
    check("collide_tov_kept", 32'(d), 32'h01);
    wr(8'h15, 8'h01);
    rd(8'h35, d);
    check("clear_tov", 32'(d), 32'h00);

    // Withdraw COMPB by masking, flag remains
    wr(8'h6E, 8'h04);
    bus.cmpb_evt = 1;
    step();
    bus.cmpb_evt = 0;
    step();
    check("wd_irq", 32'(bus.irq), 1);
    check("wd_vec", 32'(bus.irq_vec), 1);
    wr(8'h6E, 8'h00);
    check("wd_irq_hold", 32'(bus.irq), 1);
    step();
    check("wd_irq_drop", 32'(bus.irq), 0);
    rd(8'h15, d);
    check("wd_ocf0b_kept", 32'(d), 32'h04);
    wr(8'h15, 8'h04);

    // Reset during PEND
    wr(8'h6E, 8'h04);
    bus.cmpb_evt = 1;
    step();
    bus.cmpb_evt = 0;
    step();
    check("rstp_irq", 32'(bus.irq), 1);
    rst = 0;
    step();
    rst = 1;
    check("rstp_irq_drop", 32'(bus.irq), 0);
    rd(8'h15, d);
    check("rstp_tifr", 32'(d), 0);

    // External clock, rising edge
    wr(8'h25, 8'h07);
    bus.t0_pin = 1;
    step();
    check("ext_c1", 32'(bus.tick), 0);
    step();
    check("ext_c2", 32'(bus.tick), 0);
    step();
`ifdef TC0_EXT_CLK_EN
    check("ext_c3", 32'(bus.tick), 1);
`else
    check("ext_c3_disabled", 32'(bus.tick), 0);
`endif
    step();
    check("ext_c4", 32'(bus.tick), 0);

    // Randomized flags/mask/ack traffic against the model
    rst = 0;
    step();
    rst = 1;
    m_flags = '0; m_mask = '0; m_rdata = '0; m_active = 0; m_src = 0;
    for (int k = 0; k < 600; k++) begin
      logic [2:0] set, clr, p, n_flags, n_mask;
      logic       n_active;
      int         n_src;
      logic       do_wr, do_rd, ack;
      logic [7:0] wa, wd, ra, n_rdata;

      set   = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      do_wr = ($urandom_range(0, 4) == 0);
      do_rd = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       wa = 8'h6E;
        1:       wa = 8'h15;
        default: wa = 8'h35;
      endcase
      case ($urandom_range(0, 2))
        0:       ra = 8'h6E;
        1:       ra = 8'h15;
        default: ra = 8'h35;
      endcase
      wd = 8'($urandom);

      bus.ovf_evt = set[0]; bus.cmpa_evt = set[1]; bus.cmpb_evt = set[2];
      bus.io_wr_en = do_wr; bus.io_rd_en = do_rd; bus.irq_ack = ack;
      bus.io_wdata = wd;
      // Read and write share the address bus: a read uses the write address
      bus.io_addr = do_wr ? wa : ra;
      if (do_wr) ra = wa;

      p = m_flags & m_mask;
      clr = (do_wr && wa != 8'h6E) ? wd[2:0] : 3'b000;
      n_active = m_active; n_src = m_src;
      if (!m_active) begin
        if (p != 0) begin
          n_active = 1;
          n_src = (p[1]) ? 0 : (p[2]) ? 1 : 2;
        end
      end else if (ack) begin
        clr |= src_bit(m_src);
        n_active = 0;
      end else if ((p & src_bit(m_src)) == 0) begin
        n_active = 0;
      end
      n_flags = (m_flags & ~clr) | set;
      n_mask  = (do_wr && wa == 8'h6E) ? wd[2:0] : m_mask;
      n_rdata = do_rd ? ((ra == 8'h6E) ? 8'(m_mask) : 8'(m_flags)) : m_rdata;

      step();
      m_flags = n_flags; m_mask = n_mask; m_rdata = n_rdata;
      m_active = n_active; m_src = n_src;

      check($sformatf("rnd%0d_irq", k), 32'(bus.irq), 32'(m_active));
      if (m_active) check($sformatf("rnd%0d_vec", k), 32'(bus.irq_vec), 32'(m_src));
      check($sformatf("rnd%0d_rdata", k), 32'(bus.io_rdata), 32'(m_rdata));
    end
    bus.ovf_evt = 0; bus.cmpa_evt = 0; bus.cmpb_evt = 0;
    bus.io_wr_en = 0; bus.io_rd_en = 0; bus.irq_ack = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tc0_ctrl.md
# tc0_ctrl

Control and sequencing block for the 8-bit Timer/Counter0 core. It owns the timer's bus-visible registers (TCCR0A/B, OCR0A/B, TIMSK0, TIFR0 plus the TCNT0 access path), generates the prescaled count-enable tick, and arbitrates the three timer interrupt sources onto one request/acknowledge channel to the CPU interrupt unit. It sits between the CPU data bus and the counter core, which only counts on `tick` and reports events.

## Interface
Parameters:
- none; register addresses are fixed package constants.

Ports:
- `clk` in 1 — sole clock.
- `rst` in 1 — synchronous, active-low reset.
- `io_addr` in 8 — data-space address.
- `io_wr_en` in 1 — write strobe, one cycle.
- `io_rd_en` in 1 — read strobe, one cycle.
- `io_wdata` in 8 — write data.
- `io_rdata` out 8 — read data, registered.
- `tcnt_in` in 8 — current counter value from the core.
- `tcnt_wr` out 1 — one-cycle load strobe to the core.
- `tcnt_wdata` out 8 — load value.
- `tccra`, `tccrb`, `ocra`, `ocrb` out 8 each — register contents to the core.
- `ovf_evt`, `cmpa_evt`, `cmpb_evt` in 1 each — one-cycle event pulses from the core.
- `t0_pin` in 1 — external clock pin, asynchronous.
- `tick` out 1 — count enable, one-cycle pulse.
- `irq` out 1 — interrupt request.
- `irq_vec` out 2 — source code: 0 = COMPA, 1 = COMPB, 2 = OVF.
- `irq_ack` in 1 — acknowledge from the CPU.

## Operation
- **Address decode.** Each register decodes at both its I/O alias and its data alias:
  - TCCR0A 0x24/0x44, TCCR0B 0x25/0x45, TCNT0 0x26/0x46, OCR0A 0x27/0x47, OCR0B 0x28/0x48, TIFR0 0x15/0x35.
  - TIMSK0 decodes at 0x6E only.
  - Unmapped reads return 0x00. Unmapped writes are ignored.
- **Register widths.**
  - TCCR0B bits 7:6 are not stored and read 0.
  - TIMSK0 and TIFR0 implement bits 2:0 only: bit0 TOV0, bit1 OCF0A, bit2 OCF0B. Other bits read 0.
- **TCNT0 access.**
  - A write produces `tcnt_wr`=1 with `tcnt_wdata`=`io_wdata`; the controller stores nothing.
  - A read returns `tcnt_in`.
- **TIFR0 update.**
  - Each event pulse sets its flag.
  - Writing 1 to a bit clears that flag; writing 0 has no effect.
  - If a hardware set and a software clear hit the same flag in the same cycle, the set wins.
- **Prescaler.** A 10-bit free-running counter, cleared by reset. CS0 = `tccrb[2:0]` selects the tick source:
  - 0: stopped, `tick` held 0.
  - 1: every cycle.
  - 2: when `psc[2:0]` = 7.
  - 3: when `psc[5:0]` = 63.
  - 4: when `psc[7:0]` = 255.
  - 5: when `psc[9:0]` = 1023.
  - 6: external pin, falling edge.
  - 7: external pin, rising edge.
- **Interrupt FSM.** Pending set P = `tifr & timsk`. Priority order is COMPA > COMPB > OVF.
  - IDLE: `irq`=0. If P≠0, latch the highest-priority source into `irq_vec` and go to PEND.
  - PEND: `irq`=1 and `irq_vec` held stable.
    - On `irq_ack`: clear the latched flag and go to IDLE.
    - If the latched source's bit of P drops (software clear or mask change) with no ack: withdraw (`irq`=0) and go to IDLE.
    - If ack and withdraw coincide: treat as ack.
  - A higher-priority flag arriving while in PEND does not preempt. It is served on the next IDLE evaluation.

## Timing
- **Reset values.** Every stored register, `io_rdata`, `tcnt_wr`, `tcnt_wdata`, `tick`, `irq` and `irq_vec` reset to 0. The FSM resets to IDLE.
- **Register writes.** Take effect on the clock edge of the `io_wr_en` cycle; the new value is visible on the outputs the next cycle.
- **Reads.** `io_rdata` is valid one cycle after `io_rd_en` and holds until the next read.
- **TCNT0 write.** `tcnt_wr` pulses in the cycle after the write strobe.
- **Flags.** An event in cycle N sets the flag at the end of cycle N.
- **Interrupt latency.** With the mask enabled, `irq` rises in cycle N+2 (the flag is set at N, IDLE samples it at N+1). An ack in cycle M clears the flag, and `irq` is 0 in M+1. The minimum re-request gap is 1 idle cycle.
- **Internal tick.** Registered: `tick` asserts the cycle after the prescaler match. Changing CS0 does not reset the prescaler.
- **External tick.** `t0_pin` passes through a 2-FF synchronizer and an edge register. `tick` asserts 3 cycles after the pin edge, at most once per 2 cycles.
- **Reset mid-operation.** A reset during PEND drops `irq` on the next edge and clears all flags.

## Configuration
- `TC0_EXT_CLK_EN` defined: CS0 6/7 and the `t0_pin` synchronizer are built.
- Not defined: CS0 6/7 behave as stopped. The `t0_pin` port remains and is ignored, with no synchronizer flops.

## Structure
- **Package `tc0_pkg`** holds:
  - the address constants (both aliases);
  - TIFR/TIMSK bit indices;
  - the CS0 encoding enum;
  - the `irq_vec` enum;
  - the FSM state typedef.
- **Sub-module `tc0_prescaler`** holds the psc counter, the CS0 select, and the external synchronizer/edge logic, and outputs `tick`. Register decode and the interrupt FSM stay in `tc0_ctrl`.

## Test plan
- **Reset and readback.** Apply reset, then read all mapped addresses → 0x00. Write 0x5A to OCR0A at 0x27 → read at 0x47 returns 0x5A one cycle after the read strobe.
- **Prescaler /8.** Write CS0=2 → `tick` pulses exactly every 8 cycles. Switch to CS0=0 → no tick from the next cycle.
- **Interrupt priority.** Set TIMSK0=0x07 and pulse `ovf_evt` and `cmpa_evt` together:
  - `irq`=1 with `irq_vec`=0 two cycles later;
  - ack → OCF0A clears, `irq` drops 1 cycle;
  - then `irq_vec`=2.
- **Flag collision.** Write TIFR0=0x01 in the same cycle as `ovf_evt` → TOV0 remains 1. Writing 0x01 alone → TOV0 is 0.
- **Withdraw.** While in PEND for COMPB, clear TIMSK0 bit2 → `irq` falls without ack and OCF0B stays 1.
- **External clock (`TC0_EXT_CLK_EN`).** Set CS0=7 and toggle `t0_pin` 0→1 → `tick` exactly 3 cycles later. With the macro undefined → no tick.
